// File: rtl/trap_ctrl_if.sv
// Decode, CSR and fetch-redirect signals of the trap sequencer.
// slave is the sequencer side, master drives decode/CSR inputs.
interface trap_ctrl_if;
  logic        instr_valid_i;
  logic [31:0] pc_i;
  logic        ecall_i;
  logic        illegal_i;
  logic        mret_i;
  logic        irq_ext_i;
  logic        mie_i;
  logic [31:0] epc_i;
  logic        mtimecmp_we_i;
  logic [31:0] mtimecmp_wdata_i;
  logic        kill_o;
  logic        stall_o;
  logic        save_epc_o;
  logic [31:0] epc_pc_o;
  logic        restore_o;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;
  logic [31:0] mcause_o;
  logic [31:0] mtime_o;
  logic        timer_pending_o;

  modport slave (
    input  instr_valid_i, pc_i, ecall_i,
    input  illegal_i, mret_i, irq_ext_i,
    input  mie_i, epc_i,
    input  mtimecmp_we_i, mtimecmp_wdata_i,
    output kill_o, stall_o, save_epc_o,
    output epc_pc_o, restore_o, redirect_o,
    output redirect_pc_o, mcause_o,
    output mtime_o, timer_pending_o
  );

  modport master (
    output instr_valid_i, pc_i, ecall_i,
    output illegal_i, mret_i, irq_ext_i,
    output mie_i, epc_i,
    output mtimecmp_we_i, mtimecmp_wdata_i,
    input  kill_o, stall_o, save_epc_o,
    input  epc_pc_o, restore_o, redirect_o,
    input  redirect_pc_o, mcause_o,
    input  mtime_o, timer_pending_o
  );
endinterface

// File: rtl/trap_ctrl.sv
// Trap/interrupt sequencer: orders exceptions, interrupts and mret
// into trap-entry and return cycles, with a built-in machine timer.
module trap_ctrl #(
  parameter logic [31:0] MTVEC_BASE = 32'h0000_0010,
  parameter int          PRESCALE   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  trap_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    TRAP,
    MRET
  } state_e;

  localparam logic [7:0] PSC_TC = 8'(PRESCALE - 1);

  state_e      state_q;
  logic [7:0]  psc_q;
  logic [31:0] mtime_q;
  logic [31:0] mtimecmp_q;
  logic        pend_q;
  logic [31:0] epc_q;
  logic [31:0] cause_q;
  logic [31:0] mcause_q;

  logic        tick;
  logic        take_trap;
  logic        take_mret;
  logic [31:0] cause_d;

  assign tick = (psc_q == PSC_TC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc_q      <= '0;
      mtime_q    <= '0;
      mtimecmp_q <= 32'hFFFF_FFFF;
      pend_q     <= 1'b0;
    end else begin
      psc_q  <= tick ? 8'd0 : psc_q + 8'd1;
      pend_q <= (mtime_q >= mtimecmp_q);
      if (tick)
        mtime_q <= mtime_q + 32'd1;
      if (bus.mtimecmp_we_i)
        mtimecmp_q <= bus.mtimecmp_wdata_i;
    end
  end

  // Priority: exceptions ignore MIE, interrupts need it.
  always_comb begin
    take_trap = 1'b0;
    take_mret = 1'b0;
    cause_d   = '0;
    if (state_q == IDLE && bus.instr_valid_i) begin
      priority case (1'b1)
        bus.illegal_i: begin
          take_trap = 1'b1;
          cause_d   = 32'd2;
        end
        bus.ecall_i: begin
          take_trap = 1'b1;
          cause_d   = 32'd11;
        end
        bus.mret_i:
          take_mret = 1'b1;
        (bus.mie_i && bus.irq_ext_i): begin
          take_trap = 1'b1;
          cause_d   = 32'h8000_000B;
        end
        (bus.mie_i && pend_q): begin
          take_trap = 1'b1;
          cause_d   = 32'h8000_0007;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      epc_q    <= '0;
      cause_q  <= '0;
      mcause_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (take_trap) begin
            epc_q   <= bus.pc_i;
            cause_q <= cause_d;
            state_q <= TRAP;
          end else if (take_mret) begin
            state_q <= MRET;
          end
        end
        TRAP: begin
          mcause_q <= cause_q;
          state_q  <= IDLE;
        end
        MRET:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.kill_o          = take_trap | take_mret;
  assign bus.stall_o         = (state_q != IDLE);
  assign bus.save_epc_o      = (state_q == TRAP);
  assign bus.restore_o       = (state_q == MRET);
  assign bus.redirect_o      = (state_q != IDLE);
  assign bus.epc_pc_o        = epc_q;
  assign bus.mcause_o        = mcause_q;
  assign bus.mtime_o         = mtime_q;
  assign bus.timer_pending_o = pend_q;

  always_comb begin
    bus.redirect_pc_o = '0;
    if (state_q == TRAP)
      bus.redirect_pc_o = MTVEC_BASE;
    else if (state_q == MRET)
      bus.redirect_pc_o = bus.epc_i;
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: stimulus queues expected redirects,
// a monitor pops and checks them whenever redirect_o fires.
module tb_trap_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  trap_ctrl_if bus ();

  trap_ctrl #(
    .MTVEC_BASE (32'h0000_0010),
    .PRESCALE   (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    bit          is_mret;
    logic [31:0] epc;
    logic [31:0] target;
    logic [31:0] cause;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a === e) passes++;
    else $display("FAIL %s: got %h expected %h", n, a, e);
  endtask

  task automatic clear_in();
    bus.instr_valid_i = 1'b0;
    bus.pc_i          = '0;
    bus.ecall_i       = 1'b0;
    bus.illegal_i     = 1'b0;
    bus.mret_i        = 1'b0;
    bus.irq_ext_i     = 1'b0;
    bus.mie_i         = 1'b0;
  endtask

  // Kinds: 0 = no event, 1 = trap, 2 = mret.
  task automatic issue(
    logic [31:0] pc, bit ill, bit ec, bit mr, bit irq, bit mie,
    int kind, logic [31:0] target, logic [31:0] cause
  );
    exp_t e;
    @(posedge clk);
    #1;
    bus.instr_valid_i = 1'b1;
    bus.pc_i          = pc;
    bus.illegal_i     = ill;
    bus.ecall_i       = ec;
    bus.mret_i        = mr;
    bus.irq_ext_i     = irq;
    bus.mie_i         = mie;
    @(negedge clk);
    chk("kill", 32'(bus.kill_o), 32'(kind != 0));
    if (kind != 0) begin
      e.is_mret = (kind == 2);
      e.epc     = pc;
      e.target  = target;
      e.cause   = cause;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    clear_in();
    repeat (3) @(negedge clk);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.redirect_o) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_redirect", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("stall", 32'(bus.stall_o), 32'd1);
          chk("redirect_pc", bus.redirect_pc_o, e.target);
          chk("save_epc", 32'(bus.save_epc_o), 32'(!e.is_mret));
          chk("restore", 32'(bus.restore_o), 32'(e.is_mret));
          if (!e.is_mret) begin
            chk("epc_pc", bus.epc_pc_o, e.epc);
            @(negedge clk);
            chk("mcause", bus.mcause_o, e.cause);
            chk("idle_after", 32'(bus.redirect_o), 32'd0);
          end
        end
      end
    end
  end

  task automatic check_reset_vals(string tag);
    chk({tag, "_kill"}, 32'(bus.kill_o), 32'd0);
    chk({tag, "_stall"}, 32'(bus.stall_o), 32'd0);
    chk({tag, "_save"}, 32'(bus.save_epc_o), 32'd0);
    chk({tag, "_restore"}, 32'(bus.restore_o), 32'd0);
    chk({tag, "_redir"}, 32'(bus.redirect_o), 32'd0);
    chk({tag, "_redir_pc"}, bus.redirect_pc_o, 32'd0);
    chk({tag, "_epc_pc"}, bus.epc_pc_o, 32'd0);
    chk({tag, "_mcause"}, bus.mcause_o, 32'd0);
    chk({tag, "_mtime"}, bus.mtime_o, 32'd0);
    chk({tag, "_pend"}, 32'(bus.timer_pending_o), 32'd0);
  endtask

  task automatic wait_mtime(logic [31:0] v, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.mtime_o == v) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    bit ok;
    int redirs;
    clear_in();
    bus.epc_i            = 32'h0000_0104;
    bus.mtimecmp_we_i    = 1'b0;
    bus.mtimecmp_wdata_i = '0;
    #1;
    check_reset_vals("rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    issue(32'h100, 0, 1, 0, 0, 0, 1, 32'h10, 32'd11);
    issue(32'h200, 1, 1, 0, 1, 1, 1, 32'h10, 32'd2);
    issue(32'h040, 0, 0, 1, 0, 0, 2, 32'h104, 32'd0);
    chk("epc_hold", bus.epc_pc_o, 32'h200);
    chk("idle_redir_pc", bus.redirect_pc_o, 32'd0);

    // Fresh reset so the timer starts from 0 with mtimecmp = 3.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst2_mcause", bus.mcause_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus.mtimecmp_we_i    = 1'b1;
    bus.mtimecmp_wdata_i = 32'd3;
    @(posedge clk);
    #1;
    bus.mtimecmp_we_i = 1'b0;

    wait_mtime(32'd1, ok);
    chk("mtime_reach1", 32'(ok), 32'd1);
    repeat (3) @(negedge clk);
    chk("mtime_hold1", bus.mtime_o, 32'd1);
    @(negedge clk);
    chk("mtime_step2", bus.mtime_o, 32'd2);
    chk("pend_before", 32'(bus.timer_pending_o), 32'd0);
    repeat (4) @(negedge clk);
    chk("mtime_step3", bus.mtime_o, 32'd3);
    chk("pend_at3", 32'(bus.timer_pending_o), 32'd0);
    @(negedge clk);
    chk("pend_after3", 32'(bus.timer_pending_o), 32'd1);

    issue(32'h500, 0, 0, 0, 1, 1, 1, 32'h10, 32'h8000_000B);
    issue(32'h600, 0, 0, 0, 0, 1, 1, 32'h10, 32'h8000_0007);
    issue(32'h700, 0, 0, 0, 1, 0, 0, 32'h0, 32'h0);
    chk("mcause_kept", bus.mcause_o, 32'h8000_0007);

    chk("pend_still", 32'(bus.timer_pending_o), 32'd1);
    @(posedge clk);
    #1;
    bus.mtimecmp_we_i    = 1'b1;
    bus.mtimecmp_wdata_i = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    bus.mtimecmp_we_i = 1'b0;
    @(posedge clk);
    #1;
    chk("pend_clear", 32'(bus.timer_pending_o), 32'd0);

    // Reset while the ecall entry cycle is in progress.
    @(posedge clk);
    #1;
    bus.instr_valid_i = 1'b1;
    bus.pc_i          = 32'h300;
    bus.ecall_i       = 1'b1;
    @(negedge clk);
    chk("mid_kill", 32'(bus.kill_o), 32'd1);
    @(posedge clk);
    #1;
    clear_in();
    chk("mid_in_trap", 32'(bus.save_epc_o), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    redirs = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.redirect_o || bus.save_epc_o) redirs++;
    end
    chk("no_redirect_after_rst", 32'(redirs), 32'd0);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
